// File: rtl/mesh_pkg.sv
// mesh_pkg: shared defaults and width helpers for the mesh VC port.
//   PKT_W_DEF / NUM_VC_DEF / DEPTH_DEF : default parameter values
//   vc_id_w()   : width of the VC-id field (and of the polarity counter)
//   vc_id_msb() : top bit of the VC-id field; the field is [msb -: vc_id_w]
//   cnt_w()     : occupancy counter width, wide enough to hold 0..DEPTH
package mesh_pkg;

  localparam int PKT_W_DEF  = 64;
  localparam int NUM_VC_DEF = 2;
  localparam int DEPTH_DEF  = 4;

  function automatic int vc_id_w(input int num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

  function automatic int vc_id_msb(input int pkt_w);
    return pkt_w - 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mesh_vc_fifo.sv
// mesh_vc_fifo: single virtual-channel FIFO.
//   clk, reset (async, active-low)
//   push/din  : write request and data (ignored when full)
//   pop       : read request (ignored when empty)
//   full, empty, head (entry at the read pointer), count (0..DEPTH)
module mesh_vc_fifo
  import mesh_pkg::*;
#(
  parameter int W     = PKT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [W-1:0]              din,
  input  logic                      pop,
  output logic                      full,
  output logic                      empty,
  output logic [W-1:0]              head,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so pointers wrap naturally at their width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/mesh_vc_port.sv
// mesh_vc_port: time-slotted virtual-channel port.
//   clk, reset (async, active-low)
//   in_packet/si/ro : inbound packet, send request, ready (VC id in top bits)
//   out_packet/so/ri: outbound head of VC 'polarity', valid, downstream ready
//   polarity        : current output slot, advances every cycle
//   ovf_err         : sticky flag, set when si is raised while ro is low
module mesh_vc_port
  import mesh_pkg::*;
#(
  parameter int PKT_W  = PKT_W_DEF,
  parameter int NUM_VC = NUM_VC_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [PKT_W-1:0]             in_packet,
  input  logic                         si,
  output logic                         ro,
  output logic [PKT_W-1:0]             out_packet,
  output logic                         so,
  input  logic                         ri,
  output logic [vc_id_w(NUM_VC)-1:0]   polarity,
  output logic                         ovf_err
);

  localparam int VC_W = vc_id_w(NUM_VC);
  localparam int CW   = cnt_w(DEPTH);

  logic [VC_W-1:0]  in_vc;
  logic             accept;
  logic             drop;
  logic [NUM_VC-1:0] push;
  logic [NUM_VC-1:0] pop;
  logic [NUM_VC-1:0] full;
  logic [NUM_VC-1:0] empty;
  logic [PKT_W-1:0] head  [NUM_VC];
  logic [CW-1:0]    count [NUM_VC];

  assign in_vc  = in_packet[vc_id_msb(PKT_W) -: VC_W];

  // ro looks only at registered occupancy (and reset), never at si/in_packet.
  assign ro     = reset && !(|full);
  assign accept = si && ro;
  assign drop   = si && !ro;

  // count and empty are two views of the same occupancy: valid follows the
  // count, the zeroing of the data bus follows the empty flag.
  assign so         = (count[polarity] != '0);
  assign out_packet = empty[polarity] ? '0 : head[polarity];

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    assign push[g] = accept && (in_vc == VC_W'(g));
    assign pop[g]  = so && ri && (polarity == VC_W'(g));

    mesh_vc_fifo #(
      .W     (PKT_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[g]),
      .din   (in_packet),
      .pop   (pop[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .head  (head[g]),
      .count (count[g])
    );
  end

  // NUM_VC is a power of two, so the slot counter wraps at its width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      polarity <= '0;
      ovf_err  <= 1'b0;
    end else begin
      polarity <= polarity + VC_W'(1);
      if (drop) ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mesh_vc_port.sv
module tb_mesh_vc_port;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // default configuration: PKT_W=64, NUM_VC=2, DEPTH=4
  logic        rst_n;
  logic [63:0] in_packet;
  logic        si;
  logic        ro;
  logic [63:0] out_packet;
  logic        so;
  logic        ri;
  logic [0:0]  polarity;
  logic        ovf_err;

  // wide configuration: PKT_W=32, NUM_VC=4, DEPTH=8
  logic        rst4_n;
  logic [31:0] in4;
  logic        si4;
  logic        ro4;
  logic [31:0] out4;
  logic        so4;
  logic        ri4;
  logic [1:0]  pol4;
  logic        ovf4;

  mesh_vc_port dut (
    .clk        (clk),
    .reset      (rst_n),
    .in_packet  (in_packet),
    .si         (si),
    .ro         (ro),
    .out_packet (out_packet),
    .so         (so),
    .ri         (ri),
    .polarity   (polarity),
    .ovf_err    (ovf_err)
  );

  mesh_vc_port #(.PKT_W(32), .NUM_VC(4), .DEPTH(8)) dut4 (
    .clk        (clk),
    .reset      (rst4_n),
    .in_packet  (in4),
    .si         (si4),
    .ro         (ro4),
    .out_packet (out4),
    .so         (so4),
    .ri         (ri4),
    .polarity   (pol4),
    .ovf_err    (ovf4)
  );

  int          checks   = 0;
  int          failures = 0;

  // scoreboard for the default DUT
  logic [63:0] sb [2][$];
  int          m_pol = 0;
  bit          m_ovf = 1'b0;

  // scoreboard for the wide DUT
  logic [31:0] sb4 [4][$];
  int          p4 = 0;

  // One clock of the default DUT. At entry we sit #1 after a rising edge:
  // compare outputs against the scoreboard, drive inputs, update the model,
  // then advance to #1 after the next edge.
  task automatic cycle(input bit s, input logic [63:0] pkt, input bit r);
    bit          e_so;
    bit          e_ro;
    logic [63:0] e_pkt;
    int          vc;
    e_so  = (sb[m_pol].size() != 0);
    e_pkt = e_so ? sb[m_pol][0] : 64'h0;
    e_ro  = (sb[0].size() < 4) && (sb[1].size() < 4);
    checks += 5;
    if (polarity !== m_pol[0:0]) begin
      failures++; $display("FAIL cyc_polarity got=%0d exp=%0d", polarity, m_pol);
    end
    if (so !== e_so) begin
      failures++; $display("FAIL cyc_so got=%0b exp=%0b", so, e_so);
    end
    if (out_packet !== e_pkt) begin
      failures++; $display("FAIL cyc_out_packet got=%h exp=%h", out_packet, e_pkt);
    end
    if (ro !== e_ro) begin
      failures++; $display("FAIL cyc_ro got=%0b exp=%0b", ro, e_ro);
    end
    if (ovf_err !== m_ovf) begin
      failures++; $display("FAIL cyc_ovf_err got=%0b exp=%0b", ovf_err, m_ovf);
    end
    si = s; in_packet = pkt; ri = r;
    if (e_so && r) void'(sb[m_pol].pop_front());
    if (s && e_ro) begin
      vc = int'(pkt[63]);
      sb[vc].push_back(pkt);
    end
    if (s && !e_ro) m_ovf = 1'b1;
    @(posedge clk); #1;
    si = 1'b0; ri = 1'b0; in_packet = '0;
    m_pol = (m_pol + 1) % 2;
  endtask

  // Asserts reset between edges, checks the outputs react at once, then
  // releases and checks the first post-reset edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    checks += 5;
    if (ro !== 1'b0)         begin failures++; $display("FAIL rst_ro got=%0b exp=0", ro); end
    if (so !== 1'b0)         begin failures++; $display("FAIL rst_so got=%0b exp=0", so); end
    if (out_packet !== 64'h0) begin failures++; $display("FAIL rst_out got=%h exp=0", out_packet); end
    if (polarity !== 1'b0)   begin failures++; $display("FAIL rst_polarity got=%0d exp=0", polarity); end
    if (ovf_err !== 1'b0)    begin failures++; $display("FAIL rst_ovf got=%0b exp=0", ovf_err); end
    sb[0].delete(); sb[1].delete();
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_pol = 1;
    checks += 2;
    if (polarity !== 1'b1) begin failures++; $display("FAIL rst_release_polarity got=%0d exp=1", polarity); end
    if (ro !== 1'b1)       begin failures++; $display("FAIL rst_release_ro got=%0b exp=1", ro); end
  endtask

  task automatic test_reset();
    #1;
    apply_reset();
  endtask

  task automatic test_single();
    // at entry polarity is 1: push now, packet shows up in the polarity-0 slot
    cycle(1'b1, 64'h0000_0000_0000_00A5, 1'b1);
    checks += 3;
    if (polarity !== 1'b0) begin failures++; $display("FAIL single_slot got=%0d exp=0", polarity); end
    if (so !== 1'b1)       begin failures++; $display("FAIL single_so got=%0b exp=1", so); end
    if (out_packet !== 64'h0000_0000_0000_00A5) begin
      failures++; $display("FAIL single_data got=%h exp=a5", out_packet);
    end
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    checks++;
    if (so !== 1'b0) begin failures++; $display("FAIL single_empty got so=%0b exp=0", so); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) cycle(1'b1, {1'b1, 63'(i)}, 1'b0);
    checks++;
    if (ro !== 1'b0) begin failures++; $display("FAIL ovf_full_ro got=%0b exp=0", ro); end
    cycle(1'b1, {1'b1, 63'd5}, 1'b0);
    checks++;
    if (ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", ovf_err); end
    cycle(1'b0, '0, 1'b0);
  endtask

  task automatic test_drain();
    int emits;
    emits = 0;
    for (int i = 0; i < 9; i++) begin
      if (so === 1'b1) begin
        emits++;
        checks++;
        if (polarity !== 1'b1) begin
          failures++; $display("FAIL drain_slot got=%0d exp=1", polarity);
        end
      end
      cycle(1'b0, '0, 1'b1);
    end
    checks += 3;
    if (emits != 4)  begin failures++; $display("FAIL drain_count got=%0d exp=4", emits); end
    if (so !== 1'b0) begin failures++; $display("FAIL drain_empty got so=%0b exp=0", so); end
    if (ro !== 1'b1) begin failures++; $display("FAIL drain_ro got=%0b exp=1", ro); end
  endtask

  task automatic test_same_cycle();
    for (int i = 1; i <= 3; i++) cycle(1'b1, {1'b0, 55'h0, 8'(8'h10 + i)}, 1'b0);
    for (int i = 0; i < 2 && m_pol != 0; i++) cycle(1'b0, '0, 1'b0);
    cycle(1'b1, {1'b0, 55'h0, 8'h14}, 1'b1);
    checks++;
    if (dut.g_vc[0].u_fifo.count !== 3'd3) begin
      failures++; $display("FAIL same_cycle_count got=%0d exp=3", dut.g_vc[0].u_fifo.count);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
    checks++;
    if (dut.g_vc[0].u_fifo.count !== 3'd0) begin
      failures++; $display("FAIL same_cycle_drained got=%0d exp=0", dut.g_vc[0].u_fifo.count);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, {1'b0, 63'h21}, 1'b0);
    cycle(1'b1, {1'b1, 63'h31}, 1'b0);
    cycle(1'b1, {1'b0, 63'h22}, 1'b0);
    cycle(1'b1, {1'b1, 63'h32}, 1'b0);
    apply_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_random_wide();
    bit          e_so;
    bit          e_ro;
    logic [31:0] e_pkt;
    logic [31:0] pkt;
    int          vc;
    int          seq;
    seq = 0;
    @(negedge clk);
    rst4_n = 1'b1;
    @(posedge clk); #1;
    p4 = 1;
    checks++;
    if (pol4 !== 2'd1) begin failures++; $display("FAIL wide_release_pol got=%0d exp=1", pol4); end
    for (int c = 0; c < 260; c++) begin
      e_so  = (sb4[p4].size() != 0);
      e_pkt = e_so ? sb4[p4][0] : 32'h0;
      e_ro  = 1'b1;
      for (int v = 0; v < 4; v++) if (sb4[v].size() >= 8) e_ro = 1'b0;
      checks += 5;
      if (pol4 !== 2'(p4)) begin failures++; $display("FAIL wide_pol got=%0d exp=%0d", pol4, p4); end
      if (so4 !== e_so)    begin failures++; $display("FAIL wide_so got=%0b exp=%0b", so4, e_so); end
      if (out4 !== e_pkt)  begin failures++; $display("FAIL wide_out got=%h exp=%h", out4, e_pkt); end
      if (ro4 !== e_ro)    begin failures++; $display("FAIL wide_ro got=%0b exp=%0b", ro4, e_ro); end
      if (so4 === 1'b1 && out4[31:30] !== pol4) begin
        failures++; $display("FAIL wide_slot got_vc=%0d pol=%0d", out4[31:30], pol4);
      end
      vc  = int'($urandom_range(0, 3));
      pkt = {2'(vc), 6'h0, 24'(seq)};
      si4 = (c < 200) && e_ro && ($urandom_range(0, 9) < 7);
      ri4 = (c >= 200) || ($urandom_range(0, 3) != 0);
      in4 = pkt;
      if (e_so && ri4) void'(sb4[p4].pop_front());
      if (si4) begin
        sb4[vc].push_back(pkt);
        seq++;
      end
      @(posedge clk); #1;
      si4 = 1'b0; ri4 = 1'b0;
      p4 = (p4 + 1) % 4;
    end
    checks += 2;
    if (so4 !== 1'b0) begin failures++; $display("FAIL wide_drained got so=%0b exp=0", so4); end
    if (ovf4 !== 1'b0) begin failures++; $display("FAIL wide_ovf got=%0b exp=0", ovf4); end
  endtask

  initial begin
    rst_n = 1'b1; in_packet = '0; si = 1'b0; ri = 1'b0;
    rst4_n = 1'b1; in4 = '0; si4 = 1'b0; ri4 = 1'b0;
    #1;
    rst4_n = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_drain();
    test_same_cycle();
    test_reset_mid();
    test_random_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mesh_vc_port.md
MESH_VC_PORT -- requirements
Module: mesh_vc_port

Interface
REQ-001 Parameter PKT_W, 64, packet width in bits.
REQ-002 Parameter NUM_VC, 2, virtual-channel count; power of two, at least 2.
REQ-003 Parameter DEPTH, 4, per-VC FIFO depth; power of two, at least 2.
REQ-004 Port clk  in  1  sole clock; all state changes on rising edge.
REQ-005 Port reset  in  1  asynchronous, active-low reset.
REQ-006 Port in_packet  in  PKT_W  inbound packet; VC id = in_packet[PKT_W-1 -: log2(NUM_VC)].
REQ-007 Port si  in  1  inbound send request.
REQ-008 Port ro  out  1  ready to accept inbound packet.
REQ-009 Port out_packet  out  PKT_W  outbound packet (head of the selected VC).
REQ-010 Port so  out  1  outbound packet valid.
REQ-011 Port ri  in  1  downstream ready.
REQ-012 Port polarity  out  log2(NUM_VC)  current output time slot (VC eligible to send).
REQ-013 Port ovf_err  out  1  sticky protocol-error flag.

Function
REQ-014 Inbound accept SHALL occur on a rising edge where si=1 and ro=1; the packet is written to the FIFO of its VC id.
REQ-015 ro SHALL be 1 iff reset is deasserted and no VC FIFO is full; ro SHALL NOT depend combinationally on in_packet or si.
REQ-016 polarity SHALL increment by 1 every cycle after reset, wrapping from NUM_VC-1 to 0.
REQ-017 so SHALL be 1 iff the FIFO of VC == polarity is non-empty; out_packet SHALL equal that FIFO's head, else all zeros.
REQ-018 Outbound transfer SHALL occur on an edge where so=1 and ri=1; the head of VC polarity is popped; so/out_packet SHALL NOT depend combinationally on ri, si or in_packet.
REQ-019 If so=1 and ri=0, the packet SHALL remain queued and be offered again at the next slot of the same VC (NUM_VC cycles later).
REQ-020 Push and pop on the same VC in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-021 Per-VC read/write pointers SHALL wrap modulo DEPTH; occupancy counters SHALL be log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-022 Each VC SHALL preserve FIFO order; no ordering is guaranteed across VCs.
REQ-023 si=1 while ro=0 SHALL drop the packet, leave all FIFOs unchanged, and set ovf_err=1 from the next cycle until reset.
REQ-024 Latency: a packet accepted into an empty VC SHALL become eligible on so the next cycle at the earliest, i.e. at the first following cycle where polarity equals its VC.

Reset
REQ-025 While reset=0: ro=0, so=0, out_packet=0, polarity=0, ovf_err=0, all FIFOs empty, all pointers and counters 0.
REQ-026 Reset asserted mid-operation SHALL discard all queued packets immediately, without waiting for a clock edge.
REQ-027 On the first edge after reset deasserts, polarity SHALL advance to 1 and ro SHALL be 1.

Structure
REQ-028 Package mesh_pkg SHALL hold the PKT_W default, the VC-id field position, and the log2 width helper constants.
REQ-029 Sub-module mesh_vc_fifo (single-VC FIFO: push, pop, full, empty, head, count) SHALL be instantiated NUM_VC times via generate.
REQ-030 The top level SHALL contain only the polarity counter, the accept/pop decode, the head mux and the ovf_err flag.

Verification
REQ-031 Reset, then one packet 64'h0000_0000_0000_00A5 (VC0) with ri=1 -> so=1 with out_packet=64'h..A5 in the first later cycle with polarity=0; FIFO empty afterwards.
REQ-032 Push 4 VC1 packets (1,2,3,4 in the low byte) with ri=0 -> ro=0 after the 4th; si=1 with a 5th packet -> ovf_err=1, and the 5th packet is never output.
REQ-033 Release ri=1 after REQ-032 -> VC1 emits 1,2,3,4 in order, only in cycles with polarity=1, one per 2 cycles; ro returns to 1 after the first pop.
REQ-034 VC0 FIFO holding 3 packets, push and pop VC0 in the same cycle -> occupancy stays 3 and order is preserved.
REQ-035 Assert reset mid-stream with 2 packets queued per VC -> so=0 and ro=0 immediately; after release, no stale packets appear, and polarity sequence is 0,1,0,1.
REQ-036 NUM_VC=4, DEPTH=8, PKT_W=32: interleaved random VC ids -> per-VC order is preserved and VC v appears only when polarity=v.
